// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encoding, opcodes,
// control-field encodings, the control word layout and the decode-dispatch helper.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT       = 2'd0;
    localparam logic [1:0] SRCB_FOUR     = 2'd1;
    localparam logic [1:0] SRCB_IMM      = 2'd2;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    // First execution state for an opcode; unknown opcodes halt or fall back to fetch.
    function automatic state_t decode_target(input logic [5:0] op, input logic illegal_halt);
        state_t target;
        case (op)
            OP_RTYPE:        target = ST_EXEC_R;
            OP_ADDI, OP_SLTI: target = ST_EXEC_I;
            OP_LW, OP_SW:    target = ST_MEM_ADDR;
            OP_BEQ:          target = ST_BRANCH;
            OP_J:            target = ST_JUMP;
            default:         target = illegal_halt ? ST_HALT : ST_FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder for the multi-cycle controller.
// Only the FETCH write enables depend on anything besides the state (memory ready).
module mc_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       fetch_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.iord      = 1'b0;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = fetch_ready;
                ctrl.pc_write  = fetch_ready;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SHL2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_WB_R: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_WB_I: begin
                ctrl.reg_dst   = 1'b0;
                ctrl.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences the shared datapath and stalls on mem_ready_i.
// Optional MULTI_CYCLE_PERF_EN adds retired-instruction and cycle counters.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PERF_W       = 32,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        instr_op_i,
    input  logic              alu_zero_i,
    input  logic              mem_ready_i,
    output logic              pc_write_o,
    output logic              pc_write_cond_o,
    output logic [1:0]        pc_source_o,
    output logic              iord_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              ir_write_o,
    output logic              reg_dst_o,
    output logic              mem_to_reg_o,
    output logic              reg_write_o,
    output logic              alu_src_a_o,
    output logic [1:0]        alu_src_b_o,
    output logic [2:0]        alu_op_o,
    output logic              halted_o,
    output logic [3:0]        state_o,
    output logic [PERF_W-1:0] instr_cnt_o,
    output logic [PERF_W-1:0] cycle_cnt_o
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       fetch_ready;
    ctrl_t      ctrl;

    // The zero flag gates the PC load inside the datapath; the controller only raises pc_write_cond.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero_i;

    // FETCH write enables must stay low while reset holds the FSM in FETCH.
    assign fetch_ready = mem_ready_i & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= instr_op_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE:   state_d = decode_target(instr_op_i, ILLEGAL_HALT);
            ST_EXEC_R:   state_d = ST_WB_R;
            ST_EXEC_I:   state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready_i) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state       (state_q),
        .op          (op_q),
        .fetch_ready (fetch_ready),
        .ctrl        (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign pc_source_o     = ctrl.pc_source;
    assign iord_o          = ctrl.iord;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign halted_o        = ctrl.halted;
    assign state_o         = state_q;

`ifdef MULTI_CYCLE_PERF_EN
    logic [PERF_W-1:0] instr_cnt_q;
    logic [PERF_W-1:0] cycle_cnt_q;

    // Retirement is any entry into FETCH from another state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
            end
            if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
                instr_cnt_q <= instr_cnt_q + PERF_W'(1);
            end
        end
    end

    assign instr_cnt_o = instr_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
`else
    assign instr_cnt_o = '0;
    assign cycle_cnt_o = '0;
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Control FSM that sequences the shared CPU datapath (PC, register file, single ALU, unified instruction/data memory) over multiple cycles per instruction. It replaces the per-instruction combinational decoder with a state machine. Each cycle it emits the mux selects and write enables for the datapath, and it stalls on a memory ready handshake. It sits beside the datapath top and is driven by the instruction register opcode and the ALU zero flag.

Parameters:
PERF_W, 32, width of the optional performance counters
ILLEGAL_HALT, 1, 1 = an unknown opcode enters HALT; 0 = it is treated as a NOP and returns to FETCH

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset; asynchronous, active-high
instr_op_i  input  6  opcode from the instruction register, bits [31:26]
alu_zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory has completed the current read or write
pc_write_o  output  1  unconditional PC load
pc_write_cond_o  output  1  PC load when alu_zero_i=1 (beq)
pc_source_o  output  2  0 = ALU result, 1 = ALUOut register, 2 = jump target
iord_o  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
ir_write_o  output  1  instruction register load
reg_dst_o  output  1  register write address: 0 = rt, 1 = rd
mem_to_reg_o  output  1  register write data: 0 = ALUOut, 1 = MDR
reg_write_o  output  1  register file write enable
alu_src_a_o  output  1  ALU A input: 0 = PC, 1 = rs
alu_src_b_o  output  2  ALU B input: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
alu_op_o  output  3  ALU operation class: 000 add, 001 sub, 010 R-type (use funct), 011 slt
halted_o  output  1  FSM is in HALT
state_o  output  4  current state, for debug
instr_cnt_o  output  PERF_W  retired instruction count (optional feature)
cycle_cnt_o  output  PERF_W  cycles since reset (optional feature)

Behaviour:
- Reset: state = FETCH. All outputs are 0 during reset except mem_read_o=1, alu_src_b_o=1 and ir_write_o=0, which are the FETCH decodes. Counters are 0. Reset asserted mid-instruction aborts it immediately; no write enable is asserted in the cycle after reset deassertion.
- All outputs are Moore (decoded from state only), except pc_write_o and ir_write_o in FETCH, which are gated by mem_ready_i.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=000, pc_source=0.
  - If mem_ready_i=1: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise stay in FETCH with pc_write and ir_write held at 0.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08 or 0x0A -> EXEC_I
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - any other opcode -> HALT if ILLEGAL_HALT, else FETCH
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=010 -> WB_R.
- WB_R: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2; alu_op=000 for addi, 011 for slti -> WB_I.
- WB_I: reg_dst=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=000 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Stay until mem_ready_i=1, then -> WB_MEM.
- MEM_WR: iord=1, mem_write=1. Stay until mem_ready_i=1, then -> FETCH. mem_write_o stays high for the whole wait.
- WB_MEM: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=001, pc_write_cond=1, pc_source=1 -> FETCH. The datapath performs the PC load only when alu_zero_i=1.
- JUMP: pc_write=1, pc_source=2 -> FETCH.
- HALT: all enables 0, halted_o=1. Left only by reset.
- Opcode is sampled in DECODE only; instr_op_i changes in other states are ignored.
- mem_read_o and mem_write_o are never asserted in the same cycle.
- Cycles per instruction with zero wait: R/I = 4, lw = 5, sw = 4, beq/j = 3. Each cycle with mem_ready_i low adds exactly one cycle.

Optional Feature:
MULTI_CYCLE_PERF_EN
- Defined: cycle_cnt_o increments every cycle while not in HALT. instr_cnt_o increments on every transition into FETCH from a non-FETCH state (retirement). Both wrap modulo 2^PERF_W and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package cpu_ctrl_pkg: state enumeration (4-bit), opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_J, OP_LW, OP_SW), alu_op class constants, pc_source and alu_src_b encodings.
- One sub-module, mc_ctrl_decode: a purely combinational state-to-control-word decoder. It keeps the next-state logic and the output decode separate.

Test Plan:
- Reset during MEM_WR with mem_ready_i=0 -> state_o=FETCH, mem_write_o=0 in the first cycle after reset; no reg_write pulse.
- R-type (op 0x00) with mem_ready_i tied to 1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_write_o=1 only in cycle 4 with reg_dst_o=1; instr_cnt_o=1.
- lw (op 0x23) with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEM_RD -> 10 cycles total; iord_o=1 only in MEM_RD; mem_to_reg_o=1 with reg_write_o=1 in WB_MEM.
- beq (op 0x04) with alu_zero_i=0, then alu_zero_i=1 -> pc_write_cond_o=1 and pc_source_o=1 in BRANCH for both cases; 3 cycles each; pc_write_o=0 in BRANCH.
- j (op 0x02) -> pc_write_o=1 and pc_source_o=2 in the third cycle; next state FETCH.
- Illegal op 0x3F with ILLEGAL_HALT=1 -> halted_o=1 from the third cycle; all enables stay 0 for 20 cycles; cycle_cnt_o frozen.
